conv_encoder_sys: RTL and testbench
===================================

CONV_ENCODER_SYS -- requirements
Module: conv_encoder_sys

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data bits per frame.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port choose_constraint_length  input  3  code constraint length K; legal values 3-6.
REQ-005 SHALL have port in_data  input  DATA_W  frame payload, transmitted msb first.
REQ-006 SHALL have port in_valid  input  1  payload offered.
REQ-007 SHALL have port in_ready  output  1  encoder can accept a frame.
REQ-008 SHALL have port encoded_bits  output  2  symbol; [1]=parity G0, [0]=parity G1.
REQ-009 SHALL have port sym_valid  output  1  encoded_bits valid.
REQ-010 SHALL have port sym_ready  input  1  downstream (decoder_sys side) accepts symbol.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse on the last tail symbol's acceptance.

Function
REQ-012 SHALL be a rate-1/2 feedforward convolutional encoder; shift register sr[K-1:0], sr[0]=current bit, sr[i]=bit i steps earlier.
REQ-013 SHALL compute encoded_bits[1]=XOR(sr & G0), encoded_bits[0]=XOR(sr & G1), octal generators: K=3 (7,5), K=4 (17,15), K=5 (23,35), K=6 (53,75).
REQ-014 SHALL treat any choose_constraint_length outside 3-6 as K=3.
REQ-015 SHALL latch K and in_data on the cycle in_valid && in_ready; later changes to either SHALL be ignored until the next frame.
REQ-016 SHALL implement FSM IDLE -> ENCODE -> FLUSH -> IDLE.
REQ-017 SHALL assert in_ready only in IDLE.
REQ-018 IDLE -> ENCODE on in_valid && in_ready; sr cleared to zero at that edge.
REQ-019 ENCODE SHALL emit DATA_W symbols, one per accepted data bit, msb first.
REQ-020 FLUSH SHALL emit K-1 tail symbols with zero input bits, returning the trellis to state 0.
REQ-021 Frame length SHALL be exactly DATA_W+K-1 symbols (18 for K=3, 21 for K=6).
REQ-022 sym_valid SHALL rise the cycle after frame acceptance (latency 1) and stay high through the last tail symbol.
REQ-023 A symbol transfers on sym_valid && sym_ready; sr and bit counter SHALL advance only on transfer.
REQ-024 While sym_valid && !sym_ready, encoded_bits SHALL hold stable.
REQ-025 After the last tail symbol transfers: frame_done=1 that cycle, FSM -> IDLE, in_ready=1 next cycle; no back-to-back overlap.
REQ-026 Bit counter SHALL be $clog2(DATA_W+6) wide and SHALL never wrap within a frame.
REQ-027 sym_ready low for any number of cycles, including on the final symbol, SHALL cause no loss or duplication.

Reset
REQ-028 rst SHALL take priority over all other inputs, including mid-frame; the partial frame is discarded, not flushed.
REQ-029 On rst: FSM=IDLE, sr=0, counter=0, latched K=3, in_ready=0 during rst and 1 the first cycle after; encoded_bits=2'b00, sym_valid=0, frame_done=0.

Structure
REQ-030 Package conv_pkg SHALL hold DATA_W default, K_MIN=3, K_MAX=6, the generator table, and the FSM state enum; shared with decoder_sys.
REQ-031 One sub-module conv_parity_gen (combinational: sr, K -> 2-bit symbol) SHALL be instantiated; all sequencing stays in conv_encoder_sys.

Verification
REQ-032 K=3, in_data=16'h8000, sym_ready=1 -> symbols 11,10,11, then 15x00; frame_done on symbol 18.
REQ-033 K=3, in_data=16'hFFFF -> 11,01, 14x10, 01,11 (18 symbols).
REQ-034 K=6, in_data=16'h0000 -> 21 symbols of 00; in_ready low for 21 cycles.
REQ-035 K=3, 16'h8000, sym_ready toggling 1-0-1-0 -> same 18-symbol sequence; encoded_bits stable every stall cycle.
REQ-036 rst pulsed after 5 symbols -> next cycle sym_valid=0, encoded_bits=00; new frame 16'h8000 yields exactly REQ-032 sequence.
REQ-037 choose_constraint_length=7 with 16'h8000 -> identical to REQ-032; changing K to 6 mid-frame -> no effect.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional encoder/decoder pair: widths,
// constraint-length limits, generator polynomials and the FSM state type.
package conv_pkg;

    localparam int CONV_DATA_W = 16;
    localparam int K_MIN       = 3;
    localparam int K_MAX       = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_FLUSH  = 2'd2
    } conv_state_t;

    // Bit i of a generator taps sr[i]; sr[0] is the newest input bit.
    function automatic logic [K_MAX-1:0] gen0(input logic [2:0] k);
        case (k)
            3'd4:    gen0 = 6'o17;
            3'd5:    gen0 = 6'o23;
            3'd6:    gen0 = 6'o53;
            default: gen0 = 6'o07;
        endcase
    endfunction

    function automatic logic [K_MAX-1:0] gen1(input logic [2:0] k);
        case (k)
            3'd4:    gen1 = 6'o15;
            3'd5:    gen1 = 6'o35;
            3'd6:    gen1 = 6'o75;
            default: gen1 = 6'o05;
        endcase
    endfunction

    // Out-of-range constraint lengths fall back to the smallest code.
    function automatic logic [2:0] k_sanitize(input logic [2:0] k);
        if (k >= 3'(K_MIN) && k <= 3'(K_MAX))
            k_sanitize = k;
        else
            k_sanitize = 3'(K_MIN);
    endfunction

endpackage

// File: rtl/conv_parity_gen.sv
// Combinational parity generator: masks the shift register to K taps and
// produces the two generator parities for the current symbol.
module conv_parity_gen
    import conv_pkg::*;
(
    input  logic [K_MAX-1:0] sr,
    input  logic [2:0]       k,
    output logic [1:0]       sym
);

    logic [K_MAX-1:0] g0;
    logic [K_MAX-1:0] g1;
    logic [K_MAX-1:0] term0;
    logic [K_MAX-1:0] term1;

    assign g0 = gen0(k);
    assign g1 = gen1(k);

    generate
        for (genvar gi = 0; gi < K_MAX; gi++) begin : g_tap
            logic tap_en;
            assign tap_en    = (3'(gi) < k);
            assign term0[gi] = sr[gi] & g0[gi] & tap_en;
            assign term1[gi] = sr[gi] & g1[gi] & tap_en;
        end
    endgenerate

    assign sym = {^term0, ^term1};

endmodule

// File: rtl/conv_encoder_sys.sv
// Rate-1/2 feedforward convolutional encoder with per-frame constraint length,
// zero-tail termination and valid/ready symbol handshake.
module conv_encoder_sys
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        choose_constraint_length,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [1:0]        encoded_bits,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W + 6);

    conv_state_t       state_reg;
    conv_state_t       state_next;
    logic [DATA_W-1:0] data_reg;
    logic [K_MAX-2:0]  hist_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        k_reg;

    logic              accept;
    logic              xfer;
    logic              last_enc;
    logic              last_tail;
    logic              cur_bit;
    logic [K_MAX-1:0]  sr;
    logic [1:0]        parity;

    // Payload shifts out msb first with zeros behind it, so the tail bits
    // fall out of the same register without a separate mux.
    assign cur_bit   = data_reg[DATA_W-1];
    assign sr        = {hist_reg, cur_bit};
    assign accept    = in_valid && in_ready;
    assign xfer      = sym_valid && sym_ready;
    assign last_enc  = (cnt_reg == CNT_W'(DATA_W - 1));
    assign last_tail = (cnt_reg == CNT_W'(DATA_W - 2) + CNT_W'(k_reg));

    conv_parity_gen u_parity (
        .sr  (sr),
        .k   (k_reg),
        .sym (parity)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_ENCODE;
            ST_ENCODE: if (xfer && last_enc) state_next = ST_FLUSH;
            ST_FLUSH:  if (xfer && last_tail) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_reg == ST_IDLE) && !rst;
        sym_valid    = (state_reg == ST_ENCODE) || (state_reg == ST_FLUSH);
        encoded_bits = sym_valid ? parity : 2'b00;
        frame_done   = (state_reg == ST_FLUSH) && sym_ready && last_tail;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
            hist_reg <= '0;
            cnt_reg  <= '0;
            k_reg    <= 3'(K_MIN);
        end else if (accept) begin
            data_reg <= in_data;
            hist_reg <= '0;
            cnt_reg  <= '0;
            k_reg    <= k_sanitize(choose_constraint_length);
        end else if (xfer) begin
            data_reg <= {data_reg[DATA_W-2:0], 1'b0};
            hist_reg <= {hist_reg[K_MAX-3:0], cur_bit};
            cnt_reg  <= last_tail ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_encoder_sys.sv
// Self-checking bench for conv_encoder_sys: directed and random frames checked
// against a polynomial-level reference model of the convolutional code.
module tb_conv_encoder_sys;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  choose_constraint_length = 3'd3;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  encoded_bits;
    logic        sym_valid;
    logic        sym_ready = 1'b1;
    logic        frame_done;

    int passed = 0;
    int total  = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    conv_encoder_sys #(.DATA_W(16)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .choose_constraint_length (choose_constraint_length),
        .in_data                  (in_data),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .encoded_bits             (encoded_bits),
        .sym_valid                (sym_valid),
        .sym_ready                (sym_ready),
        .frame_done               (frame_done)
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Reference: each symbol is the mod-2 convolution of the bit stream
    // (payload msb first, then K-1 zeros) with the octal generators.
    function automatic void build_expected(input logic [15:0] d, input int k);
        int keff, g0, g1, nsym, b;
        logic s1, s0;
        keff = (k >= 3 && k <= 6) ? k : 3;
        case (keff)
            4:       begin g0 = 'o17; g1 = 'o15; end
            5:       begin g0 = 'o23; g1 = 'o35; end
            6:       begin g0 = 'o53; g1 = 'o75; end
            default: begin g0 = 'o7;  g1 = 'o5;  end
        endcase
        nsym = 16 + keff - 1;
        exp_q.delete();
        for (int n = 0; n < nsym; n++) begin
            s1 = 1'b0;
            s0 = 1'b0;
            for (int i = 0; i < keff; i++) begin
                b = (n - i >= 0 && n - i < 16) ? int'(d[15 - (n - i)]) : 0;
                s1 ^= (b & ((g0 >> i) & 1)) != 0;
                s0 ^= (b & ((g1 >> i) & 1)) != 0;
            end
            exp_q.push_back({s1, s0});
        end
    endfunction

    task automatic offer_frame(input logic [15:0] d, input logic [2:0] kin);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check(32'(in_ready), 32'd1, "in_ready_before_frame");
        in_data = d;
        choose_constraint_length = kin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: toggle 1-0-1-0, 2: random stalls
    task automatic run_frame(input logic [15:0] d, input logic [2:0] kin,
                             input int mode, input bit change_k);
        int idx = 0;
        int cyc = 0;
        int stalls = 0;
        logic prev_stall = 1'b0;
        logic [1:0] prev_sym = 2'b00;
        build_expected(d, int'(kin));
        offer_frame(d, kin);
        if (change_k) begin
            choose_constraint_length = 3'd6;
            in_data = 16'(($urandom));
        end
        while (idx < exp_q.size() && cyc < 400) begin
            case (mode)
                0:       sym_ready = 1'b1;
                1:       sym_ready = (cyc % 2 == 0);
                default: sym_ready = ($urandom_range(0, 99) >= 40);
            endcase
            @(negedge clk);
            check(32'(sym_valid), 32'd1, "sym_valid_in_frame");
            check(32'(in_ready), 32'd0, "in_ready_busy");
            if (prev_stall) check(32'(encoded_bits), 32'(prev_sym), "stall_hold");
            if (sym_ready) begin
                check(32'(encoded_bits), 32'(exp_q[idx]), $sformatf("sym%0d", idx));
                check(32'(frame_done), 32'(idx == exp_q.size() - 1), "frame_done");
                idx++;
            end else begin
                check(32'(frame_done), 32'd0, "frame_done_stall");
                stalls++;
            end
            prev_stall = !sym_ready;
            prev_sym = encoded_bits;
            cyc++;
            @(posedge clk); #1;
        end
        check(32'(idx), 32'(exp_q.size()), "symbol_count");
        sym_ready = 1'b1;
        @(negedge clk);
        check(32'(sym_valid), 32'd0, "sym_valid_after");
        check(32'(in_ready), 32'd1, "in_ready_after");
        $display("frame data=%04h k=%0d mode=%0d symbols=%0d stalls=%0d", d, kin, mode, idx, stalls);
        @(posedge clk); #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check(32'(in_ready), 32'd0, "rst_in_ready");
        check(32'(sym_valid), 32'd0, "rst_sym_valid");
        check(32'(encoded_bits), 32'd0, "rst_encoded");
        check(32'(frame_done), 32'd0, "rst_frame_done");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check(32'(in_ready), 32'd1, "in_ready_post_rst");
        @(posedge clk); #1;

        // directed frames
        run_frame(16'h8000, 3'd3, 0, 1'b0);
        run_frame(16'hFFFF, 3'd3, 0, 1'b0);
        run_frame(16'h0000, 3'd6, 0, 1'b0);
        run_frame(16'h8000, 3'd3, 1, 1'b0);
        run_frame(16'h8000, 3'd7, 0, 1'b1);

        // reset mid-frame after five symbols
        offer_frame(16'hA5C3, 3'd5);
        sym_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check(32'(in_ready), 32'd0, "midrst_in_ready");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check(32'(sym_valid), 32'd0, "midrst_sym_valid");
        check(32'(encoded_bits), 32'd0, "midrst_encoded");
        check(32'(in_ready), 32'd1, "midrst_in_ready_after");
        $display("reset mid-frame after 5 symbols");
        @(posedge clk); #1;
        run_frame(16'h8000, 3'd3, 0, 1'b0);

        // random frames, all K values including illegal ones
        for (int f = 0; f < 12; f++) begin
            run_frame(16'($urandom), 3'($urandom_range(0, 7)), 2, ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
